baud_gen_frac: RTL and testbench
================================

Name: baud_gen_frac

Overview:
Parametrised fractional-N baud/oversample tick generator, the successor to the fixed integer MIDI baud divider. Produces a 1-cycle oversample tick at clk/(DIV_INT + DIV_FRAC/2^FRAC_W), plus bit-centre and bit-end ticks derived from an OVS-deep oversample counter. Runtime divisor changes are glitch-free via a shadow register, and a resync input realigns phase to a detected start edge. Shared by the MIDI UART RX/TX and the generic UART cores.

Parameters:
INT_W, 16, width of integer divisor part
FRAC_W, 4, width of fractional divisor part (LSB = 1/2^FRAC_W clock)
OVS, 16, oversample ticks per bit; power of two, >= 4
RST_DIV_INT, 200, integer divisor after reset (100 MHz, MIDI 31250 baud, x16)
RST_DIV_FRAC, 0, fractional divisor after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run; low holds all counters cleared and ticks low
div_int  in  INT_W  requested integer divisor; legal >= 2
div_frac  in  FRAC_W  requested fractional divisor
div_load  in  1  1-cycle strobe capturing div_int/div_frac into shadow
resync  in  1  1-cycle strobe restarting period and oversample phase
os_tick  out  1  oversample tick, 1 cycle wide
mid_tick  out  1  os_tick coincident with oversample index OVS/2-1 (bit centre)
bit_tick  out  1  os_tick coincident with oversample index OVS-1 (bit end)
os_phase  out  $clog2(OVS)  current oversample index
cfg_err  out  1  sticky: last div_load carried an illegal div_int

Behaviour:
- Reset is one clock; clk and reset are the only clocking signals. Reset values:
  - cnt=0, acc=0, ext=0, os_phase=0, all ticks 0, cfg_err=0.
  - active = shadow = {RST_DIV_INT, RST_DIV_FRAC}, pending=0.
- Precedence: reset > !enable > resync > normal counting.
- Period: P = active_int + ext. cnt counts 0..P-1. os_tick=1 in the cycle cnt==P-1; cnt then wraps to 0 (registered output, no combinational path from inputs).
- Boundary: a cycle with os_tick=1, a resync cycle, or any !enable cycle. At each boundary:
  - {carry, acc} <= acc + active_frac (FRAC_W+1 bit add).
  - ext <= carry.
  - If pending, active <= shadow and pending <= 0; the new value governs the next period.
- Fractional example (div 3 + 8/16): periods are 3,3,4,3,4,... giving 7 cycles per 2 ticks long-run.
- div_load:
  - div_int >= 2: shadow <= inputs, pending <= 1, cfg_err <= 0.
  - div_int < 2: ignored, cfg_err <= 1.
  - Load in a boundary cycle: applied at that same boundary.
  - Back-to-back loads before a boundary: last one wins.
- resync (enable=1) in cycle t: cnt, acc, ext and os_phase cleared at t+1; no tick at t, even if cnt==P-1. First os_tick at cycle t+P', where P' = the divisor in effect after the boundary.
- os_phase increments on each os_tick and wraps OVS-1 -> 0.
  - mid_tick = os_tick & (os_phase==OVS/2-1).
  - bit_tick = os_tick & (os_phase==OVS-1).
- !enable: counters cleared as in resync, ticks forced 0, pending divisor applied. Rising enable behaves as resync.
- Width rule: internal cnt is INT_W bits. P may reach 2^INT_W (active_int max + ext), so the terminal compare uses INT_W+1 bits. No overflow allowed.
- Reset asserted mid-period: all state returns to reset values next cycle; a pending divisor is discarded.

Decomposition:
- Package baud_pkg:
  - typedef div_cfg_t (struct int/frac, widths from package constants).
  - Constants DEF_INT_W, DEF_FRAC_W, DEF_OVS, MIDI_DIV_100M=200, MIN_DIV_INT=2.
- Sub-module baud_frac_period: cnt, acc and ext registers; emits os_tick; takes active div_cfg_t and a clear input.
- Top level holds shadow/pending logic, cfg_err, and the oversample counter with mid/bit decode.

Test Plan:
- Reset, enable=1, defaults -> os_tick every 200 cycles; bit_tick every 3200; mid_tick 1600 cycles after each bit_tick; cfg_err=0.
- Load 3+8/16 -> after the next boundary, tick intervals 3,3,4,3,4,...; 16 ticks span exactly 56 cycles.
- Load div_int=1 -> cfg_err=1, period unchanged. Then load div_int=5 -> cfg_err=0, period becomes 5 after the next boundary.
- div_load in the same cycle as os_tick (200 -> 10) -> the immediately following interval is 10 cycles.
- resync at cnt=150, div=200 -> no tick at the old phase. Next os_tick exactly 200 cycles after resync, os_phase=1 after it. First mid_tick at os_tick #8 after resync.
- enable dropped mid-bit for 5 cycles, then raised -> ticks 0 throughout. First os_tick one full period after the rise, os_phase restarts at 0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared types and constants for the fractional-N baud tick generator.
package baud_pkg;

  localparam int DEF_INT_W     = 16;
  localparam int DEF_FRAC_W    = 4;
  localparam int DEF_OVS       = 16;
  localparam int MIDI_DIV_100M = 200;
  localparam int MIN_DIV_INT   = 2;

  typedef struct packed {
    logic [DEF_INT_W-1:0]  ipart;
    logic [DEF_FRAC_W-1:0] fpart;
  } div_cfg_t;

endpackage

// File: rtl/baud_frac_period.sv
// Fractional period counter: cnt/acc/ext state, emits a registered 1-cycle os_tick
// in the cycle where cnt == P-1, with P = active.ipart + ext.
module baud_frac_period
  import baud_pkg::*;
#(
  parameter int  INT_W  = DEF_INT_W,
  parameter int  FRAC_W = DEF_FRAC_W,
  parameter type cfg_t  = div_cfg_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  cfg_t active,
  output logic os_tick
);

  logic [INT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_ext;
  logic              r_tick;
  logic [INT_W:0]    w_term;
  logic [FRAC_W:0]   w_sum;

  // Tick is registered, so decide one cycle early (cnt == P-2); P can reach 2^INT_W.
  assign w_term = {1'b0, active.ipart} + {{INT_W{1'b0}}, r_ext} - (INT_W+1)'(2);
  assign w_sum  = {1'b0, r_acc} + {1'b0, active.fpart};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_ext  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= ({1'b0, r_cnt} == w_term);
      r_cnt  <= r_tick ? '0 : r_cnt + 1'b1;
      if (r_tick) {r_ext, r_acc} <= w_sum;
    end
  end

  assign os_tick = r_tick;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator with shadowed divisor, resync and
// bit-centre / bit-end decode from an OVS-deep oversample index.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int INT_W        = DEF_INT_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int OVS          = DEF_OVS,
  parameter int RST_DIV_INT  = MIDI_DIV_100M,
  parameter int RST_DIV_FRAC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [INT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  input  logic                    resync,
  output logic                    os_tick,
  output logic                    mid_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  os_phase,
  output logic                    cfg_err
);

  localparam int PH_W = $clog2(OVS);

  typedef struct packed {
    logic [INT_W-1:0]  ipart;
    logic [FRAC_W-1:0] fpart;
  } cfg_t;

  localparam cfg_t RST_CFG = '{ipart: INT_W'(RST_DIV_INT), fpart: FRAC_W'(RST_DIV_FRAC)};

  cfg_t            r_active, r_shadow, w_shadow_n;
  logic            r_pending, w_pend_n;
  logic            r_cfg_err;
  logic            r_en_q;
  logic [PH_W-1:0] r_phase;
  logic            w_load_ok, w_clear, w_tick, w_boundary;

  assign w_load_ok  = div_load && (div_int >= INT_W'(MIN_DIV_INT));
  assign w_shadow_n = w_load_ok ? cfg_t'{ipart: div_int, fpart: div_frac} : r_shadow;
  assign w_pend_n   = w_load_ok || r_pending;
  // First enabled cycle after a low period restarts phase exactly like resync.
  assign w_clear    = !enable || resync || !r_en_q;
  assign w_boundary = w_clear || w_tick;

  baud_frac_period #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W),
    .cfg_t  (cfg_t)
  ) u_period (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .active  (r_active),
    .os_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active  <= RST_CFG;
      r_shadow  <= RST_CFG;
      r_pending <= 1'b0;
      r_cfg_err <= 1'b0;
      r_en_q    <= 1'b0;
      r_phase   <= '0;
    end else begin
      r_en_q   <= enable;
      r_shadow <= w_shadow_n;
      if (div_load) r_cfg_err <= !w_load_ok;
      // A load landing on a boundary takes effect at that same boundary.
      if (w_boundary && w_pend_n) begin
        r_active  <= w_shadow_n;
        r_pending <= 1'b0;
      end else begin
        r_pending <= w_pend_n;
      end
      if (w_clear)     r_phase <= '0;
      else if (w_tick) r_phase <= r_phase + 1'b1;
    end
  end

  assign os_tick  = w_tick;
  assign mid_tick = w_tick && (r_phase == PH_W'(OVS/2-1));
  assign bit_tick = w_tick && (r_phase == PH_W'(OVS-1));
  assign os_phase = r_phase;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: periods, fractional pattern, loads, resync, enable, reset.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset, enable, div_load, resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, mid_tick, bit_tick, cfg_err;
  logic [3:0]  os_phase;

  int errs = 0;
  int checks = 0;

  baud_gen_frac dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; strobes last exactly one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    div_load = 1'b0;
    resync   = 1'b0;
  endtask

  function automatic logic hit(input int sel);
    case (sel)
      1:       return mid_tick;
      2:       return bit_tick;
      default: return os_tick;
    endcase
  endfunction

  // Cycles until the selected tick; bounded so a dead DUT fails the following check.
  task automatic wait_ev(input int sel, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!hit(sel) && n < 5000);
  endtask

  task automatic load(input int i, input int f);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
  endtask

  initial begin
    int n, s, k;
    int exp_fr[5] = '{3, 3, 4, 3, 4};
    logic seen;

    reset = 1'b1; enable = 1'b1; div_load = 1'b0; resync = 1'b0;
    div_int = 16'd200; div_frac = 4'd0;
    repeat (3) step();
    chk("rst_tick",  int'(os_tick),  0);
    chk("rst_bit",   int'(bit_tick), 0);
    chk("rst_phase", int'(os_phase), 0);
    chk("rst_err",   int'(cfg_err),  0);
    reset = 1'b0;

    wait_ev(0, n);
    wait_ev(0, n); chk("per_a", n, 200);
    wait_ev(0, n); chk("per_b", n, 200);
    chk("err0", int'(cfg_err), 0);

    wait_ev(2, n);
    chk("bit_phase", int'(os_phase), 15);
    wait_ev(1, n); chk("mid_gap", n, 1600);
    wait_ev(2, n); chk("bit_gap", n, 1600);

    // Fractional 3 + 8/16, loaded on a boundary.
    load(3, 8);
    for (int i = 0; i < 5; i++) begin
      wait_ev(0, n); chk($sformatf("frac_%0d", i), n, exp_fr[i]);
    end
    s = 0;
    for (int i = 0; i < 16; i++) begin
      wait_ev(0, n); s += n;
    end
    chk("frac_span", s, 56);

    // Illegal load ignored, then a legal load mid-period.
    load(1, 0);
    wait_ev(0, n); chk("ill_per", n, 3);
    chk("ill_err", int'(cfg_err), 1);
    step();
    load(5, 0);
    wait_ev(0, n); chk("pend_tail", n, 3);
    chk("ok_err", int'(cfg_err), 0);
    wait_ev(0, n); chk("div5_a", n, 5);
    wait_ev(0, n); chk("div5_b", n, 5);

    load(200, 0);
    wait_ev(0, n); chk("back200", n, 200);
    load(10, 0);
    wait_ev(0, n); chk("tick_load_a", n, 10);
    wait_ev(0, n); chk("tick_load_b", n, 10);

    // Resync at cnt=150 of a 200 period.
    load(200, 0);
    wait_ev(0, n); chk("pre_rs", n, 200);
    repeat (151) step();
    resync = 1'b1;
    wait_ev(0, n); chk("resync_per", n, 200);
    chk("rs_phase0", int'(os_phase), 0);
    step();
    chk("rs_phase1", int'(os_phase), 1);
    k = 1;
    do begin
      wait_ev(0, n);
      k++;
    end while (!mid_tick && k < 20);
    chk("rs_mid_idx", k, 8);

    // Enable low for 5 cycles mid-bit.
    repeat (20) step();
    enable = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (os_tick) seen = 1'b1;
    end
    enable = 1'b1;
    chk("en_quiet", int'(seen), 0);
    wait_ev(0, n); chk("en_per", n, 200);
    chk("en_phase", int'(os_phase), 0);

    // Reset mid-period discards a pending divisor and clears cfg_err.
    repeat (30) step();
    load(10, 0);
    step();
    load(0, 0);
    step();
    chk("pre_rst_err", int'(cfg_err), 1);
    reset = 1'b1;
    step();
    chk("rst2_err",   int'(cfg_err),  0);
    chk("rst2_phase", int'(os_phase), 0);
    reset = 1'b0;
    wait_ev(0, n);
    wait_ev(0, n); chk("rst2_per", n, 200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
